block_stream_mux: RTL and testbench

- Parametrised successor to the fixed 3-channel output stage of the preprocessing pipeline.
- Accepts NUM_CH independent channels of coefficient rows (e.g. Y-DCT, Cb-kron, Cr-kron), each row being LANES coefficients wide.
- Buffers each channel's rows in its own FIFO, with per-channel ready backpressure.
- Serialises whole ROWSxLANES blocks onto one 32-bit AXI4-Stream master using round-robin block arbitration, a channel tag and an end-of-block last.

---
 rtl/block_stream_pkg.sv | 25 ++
 rtl/block_stream_mux_row_fifo.sv | 52 +++++
 rtl/block_stream_mux.sv | 152 +++++++++++++++
 tb/tb_block_stream_mux.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/block_stream_pkg.sv
// Shared types, constants and elaboration helpers for the block stream multiplexer.
package block_stream_pkg;

  typedef enum logic {IDLE, SEND} state_t;

  localparam int OUT_W  = 32;
  localparam int HALF_W = 16;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic bit params_legal(input int num_ch, input int lanes, input int coef_w,
                                      input int rows, input int fifo_depth);
    return (num_ch >= 1) && (num_ch <= 8) &&
           (lanes >= 2) && (lanes % 2 == 0) &&
           (coef_w >= 2) && (coef_w <= HALF_W) &&
           (rows >= 1) && (fifo_depth >= rows) && (fifo_depth >= 2) &&
           ((fifo_depth & (fifo_depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/block_stream_mux_row_fifo.sv
// First-word-fall-through row FIFO; also exposes the row behind the head so a
// reader popping on this edge can register the following row in the same cycle.
module row_fifo
  import block_stream_pkg::*;
#(
  parameter int WIDTH = 96,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         head,
  output logic [WIDTH-1:0]         head_next,
  output logic [clog2(DEPTH):0]    count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr, rd_ptr_nx;
  logic             push_ok, pop_ok;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign push_ok   = push & ~full;
  assign pop_ok    = pop & ~empty;
  assign rd_ptr_nx = rd_ptr + AW'(1);
  assign head      = mem[rd_ptr];
  assign head_next = mem[rd_ptr_nx];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr_nx;
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/block_stream_mux.sv
// Buffers NUM_CH channels of coefficient rows and serialises whole ROWSxLANES
// blocks onto a 32-bit AXI4-Stream master with round-robin block arbitration.
module block_stream_mux
  import block_stream_pkg::*;
#(
  parameter int NUM_CH     = 3,
  parameter int LANES      = 8,
  parameter int COEF_W     = 12,
  parameter int ROWS       = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic [NUM_CH*LANES*COEF_W-1:0]   s_row_data,
  input  logic [NUM_CH-1:0]                s_row_valid,
  output logic [NUM_CH-1:0]                s_row_ready,
  output logic [OUT_W-1:0]                 m_axis_data,
  output logic                             m_axis_valid,
  input  logic                             m_axis_ready,
  output logic                             m_axis_last,
  output logic [2:0]                       m_axis_user,
  output logic [NUM_CH-1:0]                o_drop_err
);

  localparam int ROW_W = LANES * COEF_W;
  localparam int CW    = clog2(FIFO_DEPTH) + 1;
  localparam int NPAIR = LANES / 2;
  localparam int PW    = (clog2(NPAIR) < 1) ? 1 : clog2(NPAIR);
  localparam int RW    = (clog2(ROWS) < 1) ? 1 : clog2(ROWS);

  if (!params_legal(NUM_CH, LANES, COEF_W, ROWS, FIFO_DEPTH)) begin : g_bad_params
    $error("block_stream_mux: illegal parameter combination");
  end

  state_t           state;
  logic [2:0]       gnt, rr_ptr, pick;
  logic             any_elig;
  logic [PW-1:0]    pair;
  logic [RW-1:0]    row;
  logic [ROW_W-1:0] heads      [NUM_CH];
  logic [ROW_W-1:0] next_heads [NUM_CH];
  logic [CW-1:0]    counts     [NUM_CH];
  logic [NUM_CH-1:0] push, pop, full, empty, eligible;
  logic [7:0]       elig8;
  logic [2:0]       idx;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign s_row_ready[c] = ~full[c];
    assign push[c]        = s_row_valid[c] & ~full[c];
    assign pop[c]         = (state == SEND) && m_axis_ready && (gnt == 3'(c)) &&
                            (pair == PW'(NPAIR - 1)) && !empty[c];
    assign eligible[c]    = (counts[c] >= CW'(ROWS));

    row_fifo #(
      .WIDTH (ROW_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk       (i_clk),
      .rst       (i_rst),
      .push      (push[c]),
      .pop       (pop[c]),
      .din       (s_row_data[c*ROW_W +: ROW_W]),
      .head      (heads[c]),
      .head_next (next_heads[c]),
      .count     (counts[c]),
      .full      (full[c]),
      .empty     (empty[c])
    );
  end

  function automatic logic [OUT_W-1:0] pack_pair(input logic [ROW_W-1:0] r,
                                                 input logic [PW-1:0] p);
    logic signed [COEF_W-1:0] lo, hi;
    logic signed [HALF_W-1:0] lo16, hi16;
    lo   = r[(2*int'(p))*COEF_W +: COEF_W];
    hi   = r[(2*int'(p)+1)*COEF_W +: COEF_W];
    lo16 = lo;
    hi16 = hi;
    return {hi16, lo16};
  endfunction

  always_comb begin
    elig8    = 8'(eligible);
    pick     = '0;
    any_elig = 1'b0;
    idx      = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      idx = 3'((int'(rr_ptr) + i) % NUM_CH);
      if (!any_elig && elig8[idx]) begin
        any_elig = 1'b1;
        pick     = idx;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) o_drop_err <= '0;
    else       o_drop_err <= o_drop_err | (s_row_valid & full);
  end

  // At a pair wrap the head is popped on this same edge, so the next word is
  // taken from the row behind the head.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= IDLE;
      gnt          <= '0;
      rr_ptr       <= '0;
      pair         <= '0;
      row          <= '0;
      m_axis_valid <= 1'b0;
      m_axis_last  <= 1'b0;
      m_axis_data  <= '0;
      m_axis_user  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_elig) begin
            gnt          <= pick;
            m_axis_user  <= pick;
            rr_ptr       <= (pick == 3'(NUM_CH - 1)) ? '0 : pick + 3'd1;
            pair         <= '0;
            row          <= '0;
            m_axis_valid <= 1'b1;
            m_axis_data  <= pack_pair(heads[pick], '0);
            m_axis_last  <= (ROWS == 1) && (NPAIR == 1);
            state        <= SEND;
          end
        end
        SEND: begin
          if (m_axis_ready) begin
            if (m_axis_last) begin
              m_axis_valid <= 1'b0;
              m_axis_last  <= 1'b0;
              state        <= IDLE;
            end else if (pair == PW'(NPAIR - 1)) begin
              pair        <= '0;
              row         <= row + RW'(1);
              m_axis_data <= pack_pair(next_heads[gnt], '0);
              m_axis_last <= (row + RW'(1) == RW'(ROWS - 1)) && (NPAIR == 1);
            end else begin
              pair        <= pair + PW'(1);
              m_axis_data <= pack_pair(heads[gnt], pair + PW'(1));
              m_axis_last <= (row == RW'(ROWS - 1)) && (pair + PW'(1) == PW'(NPAIR - 1));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_block_stream_mux.sv
// Self-checking bench for block_stream_mux: queue-based reference model checked
// every cycle, a first-word table, and hand sequences for multi-cycle corners.
module tb_block_stream_mux;

  localparam int NUM_CH     = 3;
  localparam int LANES      = 8;
  localparam int COEF_W     = 12;
  localparam int ROWS       = 8;
  localparam int FIFO_DEPTH = 16;
  localparam int ROW_W      = LANES * COEF_W;
  localparam int NPAIR      = LANES / 2;
  localparam int WPB        = ROWS * NPAIR;

  logic                      i_clk = 1'b0;
  logic                      i_rst;
  logic [NUM_CH*ROW_W-1:0]   s_row_data;
  logic [NUM_CH-1:0]         s_row_valid;
  logic [NUM_CH-1:0]         s_row_ready;
  logic [31:0]               m_axis_data;
  logic                      m_axis_valid;
  logic                      m_axis_ready;
  logic                      m_axis_last;
  logic [2:0]                m_axis_user;
  logic [NUM_CH-1:0]         o_drop_err;

  block_stream_mux #(
    .NUM_CH     (NUM_CH),
    .LANES      (LANES),
    .COEF_W     (COEF_W),
    .ROWS       (ROWS),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .s_row_data   (s_row_data),
    .s_row_valid  (s_row_valid),
    .s_row_ready  (s_row_ready),
    .m_axis_data  (m_axis_data),
    .m_axis_valid (m_axis_valid),
    .m_axis_ready (m_axis_ready),
    .m_axis_last  (m_axis_last),
    .m_axis_user  (m_axis_user),
    .o_drop_err   (o_drop_err)
  );

  always #5 i_clk = ~i_clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: per-channel row queues plus the block currently being sent.
  logic [ROW_W-1:0]  mq [NUM_CH][$];
  bit                m_busy = 0;
  int                m_ch = 0, m_word = 0, m_rr = 0;
  logic [NUM_CH-1:0] m_drop = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int coef16(input logic [ROW_W-1:0] r, input int lane);
    int v;
    v = int'((r >> (lane * COEF_W)) & ((1 << COEF_W) - 1));
    if (v >= (1 << (COEF_W - 1))) v = v - (1 << COEF_W);
    return v & 32'hFFFF;
  endfunction

  function automatic logic [31:0] exp_word(input logic [ROW_W-1:0] r, input int p);
    return 32'((coef16(r, 2*p + 1) << 16) | coef16(r, 2*p));
  endfunction

  function automatic bit model_any_eligible();
    for (int c = 0; c < NUM_CH; c++)
      if (mq[c].size() >= ROWS) return 1;
    return 0;
  endfunction

  task automatic model_edge();
    int pre [NUM_CH];
    for (int c = 0; c < NUM_CH; c++) pre[c] = mq[c].size();
    if (i_rst) begin
      for (int c = 0; c < NUM_CH; c++) mq[c].delete();
      m_busy = 0; m_rr = 0; m_drop = '0;
      return;
    end
    if (m_busy) begin
      if (m_axis_ready) begin
        m_word++;
        if (m_word % NPAIR == 0) void'(mq[m_ch].pop_front());
        if (m_word == WPB) m_busy = 0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        int c;
        c = (m_rr + i) % NUM_CH;
        if (pre[c] >= ROWS) begin
          m_busy = 1; m_ch = c; m_word = 0; m_rr = (c + 1) % NUM_CH;
          break;
        end
      end
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (s_row_valid[c]) begin
        if (pre[c] < FIFO_DEPTH) mq[c].push_back(s_row_data[c*ROW_W +: ROW_W]);
        else m_drop[c] = 1'b1;
      end
    end
  endtask

  task automatic compare_all();
    logic [NUM_CH-1:0] exp_ready;
    for (int c = 0; c < NUM_CH; c++) exp_ready[c] = (mq[c].size() < FIFO_DEPTH);
    check("valid", m_axis_valid, m_busy);
    if (m_busy) begin
      check("data", m_axis_data, exp_word(mq[m_ch][0], m_word % NPAIR));
      check("user", m_axis_user, m_ch);
      check("last", m_axis_last, m_word == WPB - 1);
    end else begin
      check("last_idle", m_axis_last, 0);
    end
    check("row_ready", s_row_ready, exp_ready);
    check("drop_err", o_drop_err, m_drop);
  endtask

  task automatic step();
    model_edge();
    @(posedge i_clk);
    #1;
    compare_all();
  endtask

  task automatic push_row(input int c, input logic [ROW_W-1:0] r);
    s_row_data[c*ROW_W +: ROW_W] = r;
    s_row_valid[c] = 1'b1;
    step();
    s_row_valid[c] = 1'b0;
  endtask

  function automatic logic [ROW_W-1:0] rand_row();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return ROW_W'(r);
  endfunction

  task automatic drain();
    bit done;
    done = 0;
    s_row_valid  = '0;
    m_axis_ready = 1'b1;
    for (int k = 0; k < 600; k++) begin
      if (!m_busy && !model_any_eligible() && !m_axis_valid) begin
        done = 1;
        break;
      end
      step();
    end
    check("drain_done", done, 1);
  endtask

  typedef struct {
    int          ch;
    logic [11:0] l0;
    logic [11:0] l1;
    logic [31:0] word0;
  } vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t             tbl [4];
    logic [ROW_W-1:0] r;
    int               n, hs, cyc;
    bit               found;

    tbl[0] = '{1, 12'h7FF, 12'hF80, 32'hFF80_07FF};
    tbl[1] = '{2, 12'h800, 12'h005, 32'h0005_F800};
    tbl[2] = '{0, 12'hFFF, 12'h7FF, 32'h07FF_FFFF};
    tbl[3] = '{1, 12'h001, 12'h800, 32'hF800_0001};

    i_rst = 1'b1; s_row_valid = '0; s_row_data = '0; m_axis_ready = 1'b1;
    step();
    step();
    check("rst_valid", m_axis_valid, 0);
    check("rst_data",  m_axis_data, 0);
    check("rst_user",  m_axis_user, 0);
    check("rst_ready", s_row_ready, 3'b111);
    i_rst = 1'b0;

    // Single block, lane value = row*8 + lane.
    for (int rr = 0; rr < ROWS; rr++) begin
      for (int l = 0; l < LANES; l++) r[l*COEF_W +: COEF_W] = COEF_W'(rr*8 + l);
      push_row(0, r);
    end
    check("lat_after_push", m_axis_valid, 0);
    step();
    check("lat_valid", m_axis_valid, 1);
    n = 0;
    for (int k = 0; k < 40 && n < WPB; k++) begin
      if (m_axis_valid) begin
        if (n == 0)  check("t1_first", m_axis_data, 32'h0001_0000);
        if (n == 31) check("t1_lastword", m_axis_data, 32'h003F_003E);
        check("t1_user", m_axis_user, 0);
        check("t1_last", m_axis_last, n == WPB - 1);
        n++;
      end
      step();
    end
    check("t1_words", n, WPB);
    drain();

    // Table: first-word packing and sign extension per channel.
    for (int t = 0; t < 4; t++) begin
      for (int rr = 0; rr < ROWS; rr++) begin
        r = rand_row();
        if (rr == 0) begin
          r[11:0]  = tbl[t].l0;
          r[23:12] = tbl[t].l1;
        end
        push_row(tbl[t].ch, r);
      end
      found = 0;
      for (int k = 0; k < 10; k++) begin
        if (m_axis_valid) begin found = 1; break; end
        step();
      end
      check("tbl_found", found, 1);
      check("tbl_word0", m_axis_data, tbl[t].word0);
      check("tbl_user",  m_axis_user, tbl[t].ch);
      drain();
    end

    // Round-robin across three simultaneously full channels.
    i_rst = 1'b1; step(); i_rst = 1'b0;
    for (int rr = 0; rr < ROWS; rr++) begin
      for (int c = 0; c < NUM_CH; c++) s_row_data[c*ROW_W +: ROW_W] = rand_row();
      s_row_valid = '1;
      step();
    end
    s_row_valid = '0;
    begin
      int  users [$];
      int  gaps  [$];
      int  idle_run;
      bit  in_blk;
      idle_run = 0; in_blk = 0;
      for (int k = 0; k < 300 && !(users.size() == 3 && !in_blk); k++) begin
        if (m_axis_valid && !in_blk) begin
          users.push_back(m_axis_user);
          gaps.push_back(idle_run);
          in_blk = 1;
        end
        if (m_axis_valid && m_axis_ready && m_axis_last) begin
          in_blk = 0; idle_run = 0;
        end else if (!m_axis_valid) begin
          idle_run++;
        end
        step();
      end
      check("rr_blocks", users.size(), 3);
      for (int i = 0; i < 3; i++)
        if (i < users.size()) check("rr_user", users[i], i);
      for (int i = 1; i < 3; i++)
        if (i < gaps.size()) check("rr_gap", gaps[i], 1);
    end
    for (int rr = 0; rr < ROWS; rr++) push_row(0, rand_row());
    found = 0;
    for (int k = 0; k < 10; k++) begin
      if (m_axis_valid) begin found = 1; break; end
      step();
    end
    check("rr_refill_found", found, 1);
    check("rr_refill_user", m_axis_user, 0);
    drain();

    // Backpressure: ready alternates every cycle.
    for (int rr = 0; rr < ROWS; rr++) push_row(2, rand_row());
    begin
      logic [31:0] pd;
      logic [2:0]  pu;
      logic        pl;
      bit          pheld;
      pheld = 0; hs = 0; cyc = 0; pd = '0; pu = '0; pl = 1'b0;
      for (int k = 0; k < 200 && hs < WPB; k++) begin
        m_axis_ready = (k % 2 == 0);
        if (pheld) begin
          check("bp_hold_data", m_axis_data, pd);
          check("bp_hold_user", m_axis_user, pu);
          check("bp_hold_last", m_axis_last, pl);
        end
        if (m_axis_valid) cyc++;
        if (m_axis_valid && m_axis_ready) hs++;
        pheld = m_axis_valid && !m_axis_ready;
        pd = m_axis_data; pu = m_axis_user; pl = m_axis_last;
        step();
      end
      check("bp_words", hs, WPB);
      check("bp_cycles", (cyc == 2*WPB - 1) || (cyc == 2*WPB), 1);
    end
    drain();

    // FIFO full and drop on channel 1.
    m_axis_ready = 1'b0;
    for (int rr = 0; rr < FIFO_DEPTH; rr++) push_row(1, rand_row());
    check("full_ready1", s_row_ready[1], 0);
    push_row(1, rand_row());
    check("drop_set", o_drop_err, 3'b010);
    repeat (5) step();
    check("drop_sticky", o_drop_err, 3'b010);
    drain();
    check("drop_after_drain", o_drop_err, 3'b010);

    // Reset in the middle of a block.
    for (int rr = 0; rr < ROWS; rr++) push_row(0, rand_row());
    m_axis_ready = 1'b1;
    hs = 0;
    for (int k = 0; k < 40 && hs < 10; k++) begin
      if (m_axis_valid && m_axis_ready) hs++;
      step();
    end
    check("mid_words", hs, 10);
    i_rst = 1'b1; step(); i_rst = 1'b0;
    check("mid_rst_valid", m_axis_valid, 0);
    check("mid_rst_ready", s_row_ready, 3'b111);
    check("mid_rst_drop",  o_drop_err, 3'b000);
    for (int rr = 0; rr < ROWS; rr++) begin
      for (int l = 0; l < LANES; l++) r[l*COEF_W +: COEF_W] = COEF_W'(rr*16 + 12'h100 + l);
      s_row_data[0 +: ROW_W]     = r;
      s_row_data[ROW_W +: ROW_W] = rand_row();
      s_row_valid = 3'b011;
      step();
    end
    s_row_valid = '0;
    found = 0;
    for (int k = 0; k < 10; k++) begin
      if (m_axis_valid) begin found = 1; break; end
      step();
    end
    check("mid_fresh_found", found, 1);
    check("mid_fresh_user", m_axis_user, 0);
    check("mid_fresh_word0", m_axis_data, 32'h0101_0100);
    drain();

    // Randomised traffic against the model.
    for (int k = 0; k < 1500; k++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        s_row_data[c*ROW_W +: ROW_W] = rand_row();
        s_row_valid[c] = ($urandom_range(0, 9) < 3);
      end
      m_axis_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
